// File: rtl/montexp_seq.sv
// montexp_seq: left-to-right square-and-multiply sequencer that drives
// an external Montgomery multiplier one product at a time.
module montexp_seq #(
  parameter int WID    = 256,
  parameter int CNTWID = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [WID-1:0] x,
  input  logic [WID-1:0] one,
  input  logic [WID-1:0] e,
  input  logic [WID-1:0] m,
  input  logic           start,
  output logic           busy,
  output logic [WID-1:0] r,
  output logic           vld,
  output logic [WID-1:0] mm_a,
  output logic [WID-1:0] mm_b,
  output logic [WID-1:0] mm_m,
  output logic           mm_start,
  input  logic [WID-1:0] mm_r,
  input  logic           mm_vld
);

  typedef enum logic [2:0] {
    IDLE, BIT, SQR, SQRW, MUL, MULW, NEXT, DONE
  } state_t;

  state_t state, state_n;

  logic [WID-1:0]    x_r, e_r, m_r, acc;
  logic [CNTWID-1:0] idx;
  logic              seen, opmul, ebit;

  assign ebit     = e_r[idx];
  assign busy     = (state != IDLE);
  assign vld      = (state == DONE);
  assign mm_start = (state == SQR) || (state == MUL);
  assign mm_a     = acc;
  assign mm_b     = opmul ? x_r : acc;
  assign mm_m     = m_r;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = BIT;
      BIT:  state_n = seen ? SQR : NEXT;
      SQR:  state_n = SQRW;
      SQRW: if (mm_vld) state_n = ebit ? MUL : NEXT;
      MUL:  state_n = MULW;
      MULW: if (mm_vld) state_n = NEXT;
      NEXT: state_n = (idx == '0) ? DONE : BIT;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // opmul is set one state early so mm_b is already
  // correct in the mm_start cycle and holds until mm_vld.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      x_r   <= '0;
      e_r   <= '0;
      m_r   <= '0;
      acc   <= '0;
      idx   <= '0;
      seen  <= 1'b0;
      opmul <= 1'b0;
      r     <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (start) begin
            x_r  <= x;
            e_r  <= e;
            m_r  <= m;
            acc  <= one;
            idx  <= CNTWID'(WID - 1);
            seen <= 1'b0;
          end
        end
        BIT: begin
          if (seen) begin
            opmul <= 1'b0;
          end else if (ebit) begin
            acc  <= x_r;
            seen <= 1'b1;
          end
        end
        SQR: opmul <= 1'b0;
        SQRW: begin
          if (mm_vld) begin
            acc <= mm_r;
            if (ebit) opmul <= 1'b1;
          end
        end
        MUL: opmul <= 1'b1;
        MULW: if (mm_vld) acc <= mm_r;
        NEXT: begin
          if (idx == '0) r <= acc;
          else idx <= idx - CNTWID'(1);
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_montexp_seq.sv
// tb_montexp_seq: scoreboard bench for montexp_seq with a
// Montgomery multiplier model and a plain-arithmetic reference.
module tb_montexp_seq;

  localparam int WID    = 4;
  localparam int CNTWID = 2;
  localparam int L      = 3;
  localparam int MOD    = 13;
  localparam int ONE    = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [WID-1:0] x, one, e, m;
  logic           start;
  logic           busy, vld, mm_start;
  logic [WID-1:0] r, mm_a, mm_b, mm_m, mm_r;
  logic           mm_vld;

  logic           mdl_vld = 1'b0;
  logic [WID-1:0] mdl_r = '0;
  logic [WID-1:0] pr = '0;
  int             cnt = 0;
  logic           inj;

  typedef struct {
    int r;
    int lat;
    int t0;
    int base;
    int np;
  } exp_t;

  exp_t sb[$];
  logic ops[$];

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   nstart_tot = 0;
  int   rinv;
  int   cur_x;
  int   la, lb, lm;
  bit   track = 0;
  bit   prev_vld = 0;
  logic op;
  exp_t ex;

  montexp_seq #(.WID(WID), .CNTWID(CNTWID)) dut (
    .clk(clk), .rst(rst),
    .x(x), .one(one), .e(e), .m(m),
    .start(start), .busy(busy),
    .r(r), .vld(vld),
    .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_start(mm_start),
    .mm_r(mm_r), .mm_vld(mm_vld)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign mm_vld = mdl_vld | inj;
  assign mm_r   = mdl_vld ? mdl_r : WID'(7);

  task automatic chk(input string nm, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  function automatic int mont(input int a, input int b);
    return (a * b * rinv) % MOD;
  endfunction

  // Leave Montgomery form, exponentiate by repeated product, return.
  function automatic int ref_exp(input int xm, input int ee);
    int xp = (xm * rinv) % MOD;
    int p = 1;
    for (int i = 0; i < ee; i++) p = (p * xp) % MOD;
    return (p * (1 << WID)) % MOD;
  endfunction

  // Multiplier model: mm_vld lands in the L-th wait cycle.
  always @(posedge clk) begin
    mdl_vld <= 1'b0;
    if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 2) begin
        mdl_vld <= 1'b1;
        mdl_r   <= pr;
      end
    end else if (mm_start && rst) begin
      cnt <= L;
      pr  <= WID'(mont(int'(mm_a), int'(mm_b)));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      track = 0;
      prev_vld = 0;
      ops.delete();
    end else begin
      if (prev_vld) chk("vld_pulse", vld, 0);
      prev_vld = vld;
      if (mm_start) begin
        nstart_tot++;
        chk("one_inflight", int'(cnt == 0 && !mdl_vld), 1);
        chk("mm_m", mm_m, MOD);
        chk("op_expected", int'(ops.size() > 0), 1);
        if (ops.size() > 0) begin
          op = ops.pop_front();
          if (op) chk("mm_b_mul", mm_b, cur_x);
          else chk("mm_b_sqr", mm_b, mm_a);
        end
        la = mm_a;
        lb = mm_b;
        lm = mm_m;
        track = 1;
      end else if (track) begin
        chk("hold_a", mm_a, la);
        chk("hold_b", mm_b, lb);
        chk("hold_m", mm_m, lm);
        if (mm_vld) track = 0;
      end
      if (vld) begin
        chk("busy_done", busy, 1);
        chk("sb_entry", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          ex = sb.pop_front();
          chk("r", r, ex.r);
          chk("latency", cyc - ex.t0 + 1, ex.lat);
          chk("products", nstart_tot - ex.base, ex.np);
        end
      end
    end
  end

  task automatic issue(input int xi, input int ei);
    exp_t t;
    int   ms;
    int   np;
    @(negedge clk);
    x     = WID'(xi);
    e     = WID'(ei);
    m     = WID'(MOD);
    one   = WID'(ONE);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("accept", busy, 1);
    cur_x = xi;
    ms = -1;
    np = 0;
    for (int i = 0; i < WID; i++) if (ei[i]) ms = i;
    if (ms >= 0) begin
      np = ms + $countones(ei) - 1;
      for (int i = ms - 1; i >= 0; i--) begin
        ops.push_back(1'b0);
        if (ei[i]) ops.push_back(1'b1);
      end
    end
    t.r    = ref_exp(xi, ei);
    t.lat  = 2 * WID + 1 + np * (1 + L);
    t.t0   = cyc;
    t.base = nstart_tot;
    t.np   = np;
    sb.push_back(t);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (vld) break;
    end
    chk("done_seen", vld, 1);
    if (!vld) sb.delete();
  endtask

  task automatic run(input int xi, input int ei);
    issue(xi, ei);
    wait_done();
  endtask

  initial begin
    rinv = 0;
    for (int k = 1; k < MOD; k++)
      if (((1 << WID) * k) % MOD == 1) rinv = k;
    rst = 1'b0;
    start = 1'b0;
    inj = 1'b0;
    x = '0;
    e = '0;
    m = '0;
    one = '0;
    repeat (2) @(negedge clk);
    chk("rst_r", r, 0);
    chk("rst_vld", vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mm_start", mm_start, 0);
    chk("rst_mm_a", mm_a, 0);
    chk("rst_mm_b", mm_b, 0);
    chk("rst_mm_m", mm_m, 0);
    rst = 1'b1;

    run(6, 5);
    run(6, 0);
    run(6, 1);
    run(6, 15);

    // Re-pulsed start with new operands plus a stray mm_vld in BIT.
    issue(6, 5);
    @(negedge clk);
    inj = 1'b1;
    start = 1'b1;
    x = WID'(9);
    e = WID'(15);
    @(negedge clk);
    inj = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done();

    // Reset while a square is in flight; its mm_vld arrives late.
    issue(6, 5);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (mm_start) break;
    end
    chk("saw_mm_start", mm_start, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_r", r, 0);
    chk("abort_vld", vld, 0);
    chk("abort_mm_start", mm_start, 0);
    chk("abort_mm_a", mm_a, 0);
    chk("abort_mm_b", mm_b, 0);
    chk("abort_mm_m", mm_m, 0);
    for (int k = 0; k < 20 && (cnt != 0 || mdl_vld); k++)
      @(negedge clk);
    chk("late_busy", busy, 0);
    chk("late_acc", mm_a, 0);
    run(6, 5);

    for (int n = 0; n < 10; n++)
      run($urandom_range(0, MOD - 1), $urandom_range(0, 15));

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
